// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding and default width for the sequential divider.
package seq_div_pkg;
    localparam int DEF_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one restoring shift-subtract step of the divider.
module seq_div_step #(
    parameter int W = 4
) (
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] div_i,
    output logic [W:0]   rem_o,
    output logic         q_o
);
    logic [W+1:0] sh;
    assign sh    = {rem_i, bit_i};
    assign q_o   = sh >= {2'b0, div_i};
    assign rem_o = (W+1)'(q_o ? sh - {2'b0, div_i} : sh);
endmodule

// File: rtl/seq_div.sv
// seq_div: sequential restoring divider with start/ack handshake.
// Define SEQ_DIV_ZERO_CHECK_EN to short-circuit divide-by-zero with err set.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           start,
    input  logic [2*W-1:0] a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           ack,
    output logic           busy,
    output logic           err
);
    localparam int CW = $clog2(2 * W + 1);

    state_e         state_q, state_d;
    logic [2*W-1:0] dvd_q, dvd_d, quo_q, quo_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W:0]     pr_q, pr_d, step_rem;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d, step_q;

    seq_div_step #(.W(W)) u_step (
        .rem_i (pr_q),
        .bit_i (dvd_q[2*W-1]),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                dvd_d   = a;
                dvs_d   = b;
                pr_d    = '0;
                quo_d   = '0;
                cnt_d   = CW'(2 * W);
                err_d   = 1'b0;
                state_d = CALC;
`ifdef SEQ_DIV_ZERO_CHECK_EN
                if (b == '0) begin
                    quo_d   = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            CALC: begin
                dvd_d   = {dvd_q[2*W-2:0], 1'b0};
                pr_d    = step_rem;
                quo_d   = {quo_q[2*W-2:0], step_q};
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? DONE : CALC;
            end
            DONE: if (!start) begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = pr_q[W-1:0];
    assign ack       = state_q == DONE;
    assign busy      = state_q == CALC;
    assign err       = err_q;
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed bench for seq_div against an arithmetic reference model.
module tb_seq_div;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic       Clk, Rst, start;
    logic [7:0] a, quotient;
    logic [3:0] b, remainder;
    logic       ack, busy, err;

    seq_div dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .quotient  (quotient),
        .remainder (remainder),
        .ack       (ack),
        .busy      (busy),
        .err       (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: results come from / and %, timing from a countdown of compute cycles.
    logic       m_busy, m_ack, m_err;
    logic [7:0] m_q, p_q;
    logic [3:0] m_r, p_r;
    int         m_left;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_busy <= 1'b0;
            m_ack  <= 1'b0;
            m_err  <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_left <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_ack  <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
            end
        end else if (m_ack) begin
            if (!start) begin
                m_ack <= 1'b0;
                m_err <= 1'b0;
            end
        end else if (start) begin
            if (b == 4'd0) begin
                p_q <= 8'hFF;
                p_r <= ZC ? 4'd0 : a[3:0];
                if (ZC) begin
                    m_ack <= 1'b1;
                    m_err <= 1'b1;
                    m_q   <= 8'hFF;
                    m_r   <= 4'd0;
                end else begin
                    m_busy <= 1'b1;
                    m_left <= 8;
                end
            end else begin
                p_q    <= a / {4'd0, b};
                p_r    <= 4'(a % {4'd0, b});
                m_busy <= 1'b1;
                m_left <= 8;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        chk("busy", int'(busy), int'(m_busy));
        chk("ack", int'(ack), int'(m_ack));
        chk("err", int'(err), int'(m_err));
        if (!m_busy) begin
            chk("quotient", int'(quotient), int'(m_q));
            chk("remainder", int'(remainder), int'(m_r));
        end
    endtask

    task automatic run(input logic [7:0] av, input logic [3:0] bv, input int hold,
                       input logic [7:0] eq, input logic [3:0] er, input bit ee, input int elat);
        int c;
        bit got;
        c = 0;
        got = 1'b0;
        a = av;
        b = bv;
        start = 1'b1;
        while (c < 200 && !(got && !start)) begin
            tick();
            c++;
            if (!got && ack) begin
                got = 1'b1;
                chk("lit_q", int'(quotient), int'(eq));
                chk("lit_r", int'(remainder), int'(er));
                chk("lit_err", int'(err), int'(ee));
                chk("lit_latency", c - 1, elat);
            end
            if (c >= hold) start = 1'b0;
        end
        start = 1'b0;
        chk("ack_seen", int'(got), 1);
        tick();
        chk("ack_drop", int'(ack), 0);
    endtask

    initial begin
        bit got;
        Rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst_q", int'(quotient), 0);
        chk("rst_busy", int'(busy), 0);
        Rst = 1'b0;
        tick();

        run(8'd12, 4'd4, 1, 8'd3, 4'd0, 1'b0, 8);
        run(8'd200, 4'd7, 30, 8'd28, 4'd4, 1'b0, 8);
        run(8'd255, 4'd1, 1, 8'd255, 4'd0, 1'b0, 8);
        run(8'd5, 4'd9, 1, 8'd0, 4'd5, 1'b0, 8);
        run(8'd255, 4'd15, 2, 8'd17, 4'd0, 1'b0, 8);
        run(8'd37, 4'd0, 1, 8'd255, ZC ? 4'd0 : 4'd5, ZC, ZC ? 0 : 8);

        // Operand and start changes while computing must not disturb the result.
        a = 8'd100;
        b = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 8'd250;
        b = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = '0;
        b = '0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            got = ack;
        end
        chk("mid_ack_seen", int'(got), 1);
        chk("mid_q", int'(quotient), 33);
        chk("mid_r", int'(remainder), 1);
        tick();

        // Asynchronous reset in the middle of a computation.
        a = 8'd50;
        b = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 Rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ack", int'(ack), 0);
        chk("arst_q", int'(quotient), 0);
        chk("arst_r", int'(remainder), 0);
        chk("arst_err", int'(err), 0);
        @(negedge Clk);
        Rst = 1'b0;
        tick();
        run(8'd50, 4'd5, 1, 8'd10, 4'd0, 1'b0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
